pc_unit: RTL and testbench

Parametrised program counter for the single-cycle/multi-cycle MIPS cores. It generalises the earlier two-source PC (sequential increment or one alternative target) to a full next-PC unit with stall, PC-relative branch, absolute jump, and call/return through an internal circular return-address stack (RAS). It sits at the head of instruction fetch and drives the instruction-memory address every cycle.

---
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Next-PC unit for the MIPS fetch stage: stall, PC-relative branch, absolute jump,
// and call/return through a circular return-address stack.
module pc_unit #(
  parameter int unsigned            WIDTH        = 32,
  parameter logic [WIDTH-1:0]       RESET_VECTOR = '0,
  parameter int unsigned            INCR         = 4,
  parameter int unsigned            RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branch_en,
  input  logic [WIDTH-1:0]                 branch_offset,
  input  logic                             jump_en,
  input  logic [WIDTH-1:0]                 jump_target,
  input  logic                             call_en,
  input  logic                             ret_en,
  output logic [WIDTH-1:0]                 pc,
  output logic [WIDTH-1:0]                 pc_seq,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  assign pc_seq = pc_q + WIDTH'(INCR);

  // ptr_q is the next free slot; once full it lands on the oldest entry, so
  // overwrite-on-full is an ordinary push.
  assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    ras_d = ras_q;
    if (!stall) begin
      if (ret_en) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[ptr_dec];
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d  = pc_seq;
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        ras_d[ptr_q] = pc_seq;
        ptr_d        = ptr_inc;
        pc_d         = jump_target;
        if (cnt_q == CNT_W'(RAS_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (jump_en) begin
        pc_d = jump_target;
      end else if (branch_en) begin
        pc_d = pc_seq + (branch_offset << 2);
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ras_q <= ras_d;
    end
  end

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 32-bit and an 8-bit instance share stimulus; a queue-based
// model predicts the 32-bit PC, and the 8-bit PC must equal its low byte.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_en, jump_en, call_en, ret_en;
  logic [31:0] branch_offset, jump_target;

  logic [31:0] pc, pc_seq;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;
  logic [7:0]  pc8, pc_seq8;
  logic [2:0]  ras_count8;
  logic        ras_overflow8, ras_underflow8;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .INCR(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_target(jump_target),
    .call_en(call_en), .ret_en(ret_en), .pc(pc), .pc_seq(pc_seq),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h0), .INCR(4), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_offset(branch_offset[7:0]), .jump_en(jump_en), .jump_target(jump_target[7:0]),
    .call_en(call_en), .ret_en(ret_en), .pc(pc8), .pc_seq(pc_seq8),
    .ras_count(ras_count8), .ras_overflow(ras_overflow8), .ras_underflow(ras_underflow8)
  );

  // Reference model: return addresses live in a queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;
  logic        cmp_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc  = 32'h0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic m_step();
    logic [31:0] seq;
    if (stall) return;
    seq = m_pc + 32'd4;
    if (ret_en) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = seq;
        m_unf = 1'b1;
      end
    end else if (call_en) begin
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(seq);
      m_pc = jump_target;
    end else if (jump_en)   m_pc = jump_target;
    else if (branch_en)     m_pc = seq + (branch_offset * 32'd4);
    else                    m_pc = seq;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("pc_seq", pc_seq, m_pc + 32'd4);
      chk("ras_count", {29'd0, ras_count}, 32'(m_ras.size()));
      chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
      chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_unf});
      chk("pc8", {24'd0, pc8}, {24'd0, m_pc[7:0]});
      chk("pc_seq8", {24'd0, pc_seq8}, {24'd0, 8'(m_pc[7:0] + 8'd4)});
      chk("ras_count8", {29'd0, ras_count8}, 32'(m_ras.size()));
      chk("flags8", {30'd0, ras_overflow8, ras_underflow8}, {30'd0, m_ovf, m_unf});
    end
  end

  // Apply one cycle of controls at a negedge, advance the model at the posedge.
  task automatic tick(input logic s, input logic r, input logic c, input logic j,
                      input logic b, input logic [31:0] tgt, input logic [31:0] off);
    stall = s; ret_en = r; call_en = c; jump_en = j; branch_en = b;
    jump_target = tgt; branch_offset = off;
    @(posedge clk);
    m_step();
    @(negedge clk);
    stall = 0; ret_en = 0; call_en = 0; jump_en = 0; branch_en = 0;
    jump_target = '0; branch_offset = '0;
  endtask

  task automatic idle();                  tick(0, 0, 0, 0, 0, 32'h0, 32'h0); endtask
  task automatic jmp(input logic [31:0] t); tick(0, 0, 0, 1, 0, t, 32'h0);   endtask
  task automatic call(input logic [31:0] t); tick(0, 0, 1, 0, 0, t, 32'h0);  endtask
  task automatic ret();                   tick(0, 1, 0, 0, 0, 32'h0, 32'h0); endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    m_reset();
    #1;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_cnt", {29'd0, ras_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; ret_en = 0; call_en = 0; jump_en = 0; branch_en = 0;
    jump_target = '0; branch_offset = '0;
    m_reset();
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_pc", pc, 32'h0);
    chk("reset_pc_seq", pc_seq, 32'h4);

    // Sequential
    idle(); chk("seq1", pc, 32'h4);
    idle(); chk("seq2", pc, 32'h8);
    idle(); chk("seq3", pc, 32'hC);
    async_reset();

    // Branch and jump priority
    jmp(32'h10);
    tick(0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFE); chk("branch_back", pc, 32'h0C);
    tick(0, 0, 0, 1, 1, 32'h100, 32'h5);       chk("jump_over_branch", pc, 32'h100);

    // Stall holds everything, including a pending jump
    jmp(32'h20);
    tick(1, 0, 0, 1, 0, 32'h40, 32'h0); chk("stall1", pc, 32'h20);
    tick(1, 0, 0, 1, 0, 32'h40, 32'h0); chk("stall2", pc, 32'h20);
    idle(); chk("stall_release", pc, 32'h24);

    // Nested call/return
    async_reset();
    call(32'h40); call(32'h80); call(32'hC0);
    chk("nest_cnt", {29'd0, ras_count}, 32'd3);
    ret(); chk("nest_ret1", pc, 32'h84);
    ret(); chk("nest_ret2", pc, 32'h44);
    ret(); chk("nest_ret3", pc, 32'h04);
    chk("nest_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);

    // Overflow then underflow
    call(32'h100); call(32'h200); call(32'h300); call(32'h400); call(32'h500);
    chk("ovf_flag", {31'd0, ras_overflow}, 32'd1);
    chk("ovf_cnt", {29'd0, ras_count}, 32'd4);
    ret(); chk("ovf_ret1", pc, 32'h404);
    ret(); chk("ovf_ret2", pc, 32'h304);
    ret(); chk("ovf_ret3", pc, 32'h204);
    ret(); chk("ovf_ret4", pc, 32'h104);
    ret(); chk("unf_pc", pc, 32'h108);
    chk("unf_flag", {31'd0, ras_underflow}, 32'd1);

    // Call and return together: return wins, no push
    call(32'h600);
    tick(0, 1, 1, 0, 0, 32'h700, 32'h0); chk("ret_over_call", pc, 32'h10C);
    chk("ret_over_call_cnt", {29'd0, ras_count}, 32'd0);

    // Stalled return leaves RAS intact
    call(32'h50);
    tick(1, 1, 0, 0, 0, 32'h0, 32'h0); chk("stall_ret", pc, 32'h50);
    ret(); chk("after_stall_ret", pc, 32'h110);

    // Wrap-around, 8-bit and 32-bit
    jmp(32'hFC);
    idle(); chk("wrap8_seq", {24'd0, pc8}, 32'h00); chk("wrap32_no", pc, 32'h100);
    jmp(32'h10);
    tick(0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFF8);
    chk("wrap8_branch", {24'd0, pc8}, 32'hF4); chk("wrap32_branch", pc, 32'hFFFF_FFF4);
    jmp(32'hFFFF_FFFC);
    idle(); chk("wrap32_seq", pc, 32'h0);

    // Sticky flags survive further activity until reset
    idle();
    chk("sticky", {30'd0, ras_overflow, ras_underflow}, 32'd3);
    async_reset();
    chk("flags_cleared", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    idle();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
